// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
//   op_e           : operation select (OP_ADD = A+B, OP_SUB = A-B)
//   addsub_flags_t : status flags registered alongside each result
//   sat_limits()   : signed clamp values for a given operand width
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

  // Widest operand the clamp helper supports; callers slice the low bits.
  localparam int unsigned SatMaxWidth = 64;

  typedef struct packed {
    logic [SatMaxWidth-1:0] pos;
    logic [SatMaxWidth-1:0] neg;
  } sat_lim_t;

  // pos = 2^(width-1)-1, neg = 2^(width-1) (i.e. the most negative value).
  function automatic sat_lim_t sat_limits(input int unsigned width);
    sat_lim_t lim;
    lim.neg = SatMaxWidth'(1) << (width - 1);
    lim.pos = lim.neg - SatMaxWidth'(1);
    return lim;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage of pipe_addsub: ripples chunk Idx of the operands using the
// carry registered by the previous stage and registers everything for the next.
// The last stage also derives the status flags and, with ADDSUB_SAT_EN defined,
// applies the signed clamp.
//   clk, rst       : clock, synchronous active-high reset
//   hold           : global stall, keeps all registers unchanged
//   up_*           : contents handed over by the previous stage (or the input)
//   dn_*           : this stage's registered contents
//   dn_flags       : registered flags (meaningful only in the last stage)
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Cw    = 4,
  parameter int unsigned Idx   = 0,
  parameter bit          Last  = 1'b0,
  parameter int unsigned TagW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             up_valid,
  input  logic [Width-1:0] up_a,
  input  logic [Width-1:0] up_b,
  input  logic [Width-1:0] up_res,
  input  logic             up_carry,
  input  logic [TagW-1:0]  up_tag,
  input  logic             up_sat,
  output logic             dn_valid,
  output logic [Width-1:0] dn_a,
  output logic [Width-1:0] dn_b,
  output logic [Width-1:0] dn_res,
  output logic             dn_carry,
  output logic [TagW-1:0]  dn_tag,
  output logic             dn_sat,
  output addsub_flags_t    dn_flags
);

  logic [Cw:0]      c;
  logic [Cw-1:0]    sum;
  logic [Width-1:0] res_d;
  logic             ovf;
  addsub_flags_t    flags_d;

  assign c[0] = up_carry;

  for (genvar i = 0; i < Cw; i++) begin : g_fa
    full_adder u_fa (
      .a    (up_a[Idx*Cw+i]),
      .b    (up_b[Idx*Cw+i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // Carry into the chunk MSB vs carry out of it; only meaningful in the last stage.
  assign ovf = c[Cw] ^ c[Cw-1];

`ifdef ADDSUB_SAT_EN
  localparam sat_lim_t SatLim = sat_limits(Width);
`endif

  always_comb begin
    res_d                = up_res;
    res_d[Idx*Cw +: Cw]  = sum;
    flags_d              = '0;
    if (Last) begin
`ifdef ADDSUB_SAT_EN
      // Operand A's sign tells overflow direction (both effective operands agree).
      if (up_sat && ovf) begin
        res_d = up_a[Width-1] ? SatLim.neg[Width-1:0] : SatLim.pos[Width-1:0];
      end
`endif
      flags_d.cout = c[Cw];
      flags_d.ovf  = ovf;
      flags_d.zero = (res_d == '0);
      flags_d.neg  = res_d[Width-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_a     <= '0;
      dn_b     <= '0;
      dn_res   <= '0;
      dn_carry <= 1'b0;
      dn_tag   <= '0;
      dn_sat   <= 1'b0;
      dn_flags <= '0;
    end else if (!hold) begin
      dn_valid <= up_valid;
      dn_a     <= up_a;
      dn_b     <= up_b;
      dn_res   <= res_d;
      dn_carry <= c[Cw];
      dn_tag   <= up_tag;
      dn_sat   <= up_sat;
      dn_flags <= flags_d;
    end
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addends and carry in
//   s, cout   : sum and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshakes.
// The operands are split into STAGES chunks of WIDTH/STAGES bits; each stage
// ripples one chunk, so an accepted operation appears STAGES edges later.
// Optional saturation is enabled by defining the macro ADDSUB_SAT_EN, which adds
// the in_sat port and the clamp in the final stage.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operation handshake (in_ready = !stall)
//   in_a, in_b, in_op     : operands and op (0 = ADD, 1 = SUB)
//   in_tag                : opaque tag returned with the result
//   in_sat                : saturation request (ADDSUB_SAT_EN only)
//   out_valid/out_ready   : result handshake
//   out_res, out_tag      : result and its tag
//   out_cout/ovf/zero/neg : status flags of the result
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Index k is the input of stage k; index STAGES is the output register.
  logic [STAGES:0]            v_q;
  logic [STAGES:0][WIDTH-1:0] a_q;
  logic [STAGES:0][WIDTH-1:0] b_q;
  logic [STAGES:0][WIDTH-1:0] r_q;
  logic [STAGES:0]            c_q;
  logic [STAGES:0][TAG_W-1:0] t_q;
  logic [STAGES:0]            s_q;
  addsub_flags_t              fl_q [STAGES];

  op_e  op;
  logic stall;

  assign op       = op_e'(in_op);
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // SUB is A + ~B + 1: invert B up front and use op as the stage-0 carry in.
  assign v_q[0] = in_valid && in_ready;
  assign a_q[0] = in_a;
  assign b_q[0] = (op == OP_SUB) ? ~in_b : in_b;
  assign r_q[0] = '0;
  assign c_q[0] = (op == OP_SUB);
  assign t_q[0] = in_tag;
`ifdef ADDSUB_SAT_EN
  assign s_q[0] = in_sat;
`else
  assign s_q[0] = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .Width (WIDTH),
      .Cw    (CW),
      .Idx   (k),
      .Last  (k == STAGES - 1),
      .TagW  (TAG_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .hold     (stall),
      .up_valid (v_q[k]),
      .up_a     (a_q[k]),
      .up_b     (b_q[k]),
      .up_res   (r_q[k]),
      .up_carry (c_q[k]),
      .up_tag   (t_q[k]),
      .up_sat   (s_q[k]),
      .dn_valid (v_q[k+1]),
      .dn_a     (a_q[k+1]),
      .dn_b     (b_q[k+1]),
      .dn_res   (r_q[k+1]),
      .dn_carry (c_q[k+1]),
      .dn_tag   (t_q[k+1]),
      .dn_sat   (s_q[k+1]),
      .dn_flags (fl_q[k])
    );
  end

  assign out_valid = v_q[STAGES];
  assign out_res   = r_q[STAGES];
  assign out_tag   = t_q[STAGES];
  assign out_cout  = fl_q[STAGES-1].cout;
  assign out_ovf   = fl_q[STAGES-1].ovf;
  assign out_zero  = fl_q[STAGES-1].zero;
  assign out_neg   = fl_q[STAGES-1].neg;

  // Operands, carry and sat leaving the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES], b_q[STAGES], c_q[STAGES], s_q[STAGES]};

endmodule

// File: tb/tb_pipe_addsub.sv
module tb_pipe_addsub;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;
  localparam int unsigned TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic [TAG_W-1:0] in_tag;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
`ifdef ADDSUB_SAT_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] want);
    nvec++;
    assert (obs === want)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", name, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an empty pipe (out_ready=1) and check latency and result.
  // flags = {cout, ovf, zero, neg}
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic sat, input logic [3:0] tag,
                        input logic [15:0] res, input logic [3:0] flags);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_sat   = sat;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({name, "/early"}, 32'(out_valid), 32'd0);
    tick();
    chk({name, "/valid"}, 32'(out_valid), 32'd1);
    chk({name, "/res"}, 32'(out_res), 32'(res));
    chk({name, "/tag"}, 32'(out_tag), 32'(tag));
    chk({name, "/flags"}, 32'({out_cout, out_ovf, out_zero, out_neg}), 32'(flags));
    tick();
  endtask

  initial begin
    logic [3:0]  rdy_pat;
    logic        held;
    logic [15:0] hres;
    logic [3:0]  htag;
    int          idx;
    int          got;
    int          extra;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 1'b0;
    in_tag    = '0;
    in_sat    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    chk("rst/out_res", 32'(out_res), 32'd0);
    chk("rst/out_tag", 32'(out_tag), 32'd0);
    chk("rst/flags", 32'({out_cout, out_ovf, out_zero, out_neg}), 32'd0);

    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd3, 16'h8000, 4'b0101);
    run_op("sub_brw",  16'h0000, 16'h0001, 1'b1, 1'b0, 4'd5, 16'hFFFF, 4'b0001);
    run_op("sub_zero", 16'h1234, 16'h1234, 1'b1, 1'b0, 4'd6, 16'h0000, 4'b1010);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd7, 16'h0000, 4'b1010);
    run_op("add_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 4'd8, 16'h1000, 4'b0000);
    run_op("sub_novf", 16'h8000, 16'h0001, 1'b1, 1'b0, 4'd9, 16'h7FFF, 4'b1100);

    // Back-to-back ADDs with out_ready cycling 1,0,0,1.
    rdy_pat = 4'b1001;
    held    = 1'b0;
    hres    = '0;
    htag    = '0;
    idx     = 0;
    got     = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      if (held) begin
        chk("hs/hold_res", 32'(out_res), 32'(hres));
        chk("hs/hold_tag", 32'(out_tag), 32'(htag));
      end
      in_valid  = (idx < 8);
      in_a      = 16'(idx);
      in_b      = 16'(idx << 8);
      in_op     = 1'b0;
      in_sat    = 1'b0;
      in_tag    = 4'(idx);
      out_ready = rdy_pat[cyc % 4];
      #1;
      held = 1'b0;
      if (out_valid && !out_ready) begin
        chk("hs/in_ready_stall", 32'(in_ready), 32'd0);
        held = 1'b1;
        hres = out_res;
        htag = out_tag;
      end else if (out_valid) begin
        chk("hs/tag", 32'(out_tag), 32'(got));
        chk("hs/res", 32'(out_res), 32'(16'(got * 16'h0101)));
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("hs/count", 32'(got), 32'd8);
    chk("hs/issued", 32'(idx), 32'd8);
    extra = 0;
    repeat (8) begin
      if (out_valid) extra++;
      tick();
    end
    chk("hs/extra", 32'(extra), 32'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'h0100 + 16'(i);
      in_b     = 16'h0001;
      in_op    = 1'b0;
      in_tag   = 4'(9 + i);
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst/out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst/out_res", 32'(out_res), 32'd0);
    chk("mid_rst/out_tag", 32'(out_tag), 32'd0);
    chk("mid_rst/flags", 32'({out_cout, out_ovf, out_zero, out_neg}), 32'd0);
    chk("mid_rst/in_ready", 32'(in_ready), 32'd1);
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      tick();
    end
    chk("mid_rst/ghosts", 32'(extra), 32'd0);
    run_op("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'd2, 16'h3333, 4'b0000);

`ifdef ADDSUB_SAT_EN
    run_op("sat_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 4'd1, 16'h7FFF, 4'b0100);
    run_op("sat_neg",  16'h8000, 16'h0001, 1'b1, 1'b1, 4'd2, 16'h8000, 4'b1101);
    run_op("wrap_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd3, 16'h8000, 4'b0101);
    run_op("wrap_neg", 16'h8000, 16'h0001, 1'b1, 1'b0, 4'd4, 16'h7FFF, 4'b1100);
    run_op("sat_none", 16'h1000, 16'h0234, 1'b0, 1'b1, 4'd5, 16'h1234, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes, status flags and an optional saturating mode. The operand width is split into `STAGES` equal chunks. Each pipeline stage ripples one chunk and registers the carry into the next stage, so clock rate scales with `STAGES`. The block sits between operand-issue logic and a result consumer in the datapath, and replaces the single-cycle combinational adder/subtractor where wide operands or backpressure are needed.

## Interface
- `WIDTH`, 16, operand/result width; must be divisible by `STAGES`.
- `STAGES`, 4, pipeline depth and chunk count; chunk width `CW = WIDTH/STAGES`, CW ≥ 1.
- `TAG_W`, 4, width of the opaque tag carried alongside each operation.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block accepts the operation this cycle.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `in_op` in 1: 0 = ADD (A+B), 1 = SUB (A−B).
- `in_tag` in TAG_W: passed through unchanged.
- `in_sat` in 1: request saturation; present only with `ADDSUB_SAT_EN`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `out_res` out WIDTH: result.
- `out_tag` out TAG_W: tag of this result.
- `out_cout` out 1: carry out of the MSB. For SUB, 1 means no borrow.
- `out_ovf` out 1: signed overflow of the unsaturated result.
- `out_zero` out 1: `out_res == 0`, evaluated after any saturation.
- `out_neg` out 1: `out_res[WIDTH-1]`.

## Operation
- SUB is performed as A + ~B + 1. Stage 0 receives B XOR {WIDTH{op}} with carry-in = op.
- Stage k adds bits [k·CW +: CW] using the registered carry from stage k−1.
  - Operand bits not yet consumed are skewed forward through the pipeline registers.
  - Result chunks already computed are carried forward to the output.
- Each stage holds a valid bit. Stage k's registered carry-out feeds stage k+1.
- `out_ovf` = carry into MSB XOR carry out of MSB, computed inside the last stage.
- Flags are registered together with `out_res` and are stable while `out_valid && !out_ready`.
- Stall is global: `stall = out_valid && !out_ready`. While stalled, every stage holds its contents.
- `in_ready = !stall`. This is combinational from `out_valid` and `out_ready` only, never from `in_valid`.
- An operation is accepted on `in_valid && in_ready`. A result retires on `out_valid && out_ready`.
- Pipeline bubbles advance even when the output holds nothing; there is no compaction beyond the normal advance.
- Results leave strictly in acceptance order. No operation is dropped or duplicated.

## Timing
- Latency: an operation accepted at edge N gives `out_valid=1` after edge N+STAGES, assuming no stall.
- Throughput: one operation per cycle while `out_ready=1`.
- Simultaneous accept and retire in the same cycle is legal and required at full throughput.
- Reset values:
  - All stage valids = 0, so `out_valid=0`.
  - `out_res`, `out_tag` and all flags = 0.
  - `in_ready=1` after reset.
- Reset mid-operation discards all in-flight operations with no output, and holds priority over the handshake.
- With `STAGES=1`, the block is a single registered ripple adder with latency 1.

## Configuration
- Macro `ADDSUB_SAT_EN`.
- Defined:
  - Port `in_sat` exists and is registered through the pipeline with its operation.
  - When `sat=1` and signed overflow occurs, `out_res` clamps to 2^(WIDTH−1)−1 on positive overflow (operand sign 0) and to −2^(WIDTH−1) on negative overflow.
  - `out_ovf` still reports the overflow.
  - `out_cout` is unchanged.
- Undefined:
  - No `in_sat` port.
  - Results always wrap modulo 2^WIDTH.
  - The clamp logic is not generated.

## Structure
- Package `addsub_pkg`:
  - `op_e` enum: `OP_ADD=0`, `OP_SUB=1`.
  - `addsub_flags_t` struct: `{cout, ovf, zero, neg}`.
  - Helper function computing the saturation limits for a given width.
- Sub-module `addsub_stage`, one instance per stage via generate:
  - Holds one chunk's ripple sum plus its valid, carry, skewed-operand and result registers, with a hold input driven by the stall.
  - The existing `full_adder` cell is reused inside it.

## Test plan
All scenarios use WIDTH=16, STAGES=4.

- ADD 0x7FFF + 0x0001, tag 3 → after 4 cycles: res 0x8000, ovf=1, neg=1, cout=0, zero=0, tag 3.
- SUB 0x0000 − 0x0001 → res 0xFFFF, cout=0 (borrow), ovf=0, neg=1.
- SUB 0x1234 − 0x1234 → res 0x0000, zero=1, cout=1, ovf=0.
- Handshake ordering:
  - Stimulus: 8 back-to-back ADDs (i + 0x0100i, tags 0–7) while `out_ready` toggles 1,0,0,1 repeatedly.
  - Required: exactly 8 results, in tag order, with correct sums.
  - Required: `in_ready=0` on every stalled cycle, and outputs held stable while stalled.
- Reset mid-operation: assert `rst` for 1 cycle while 3 operations are in flight → no `out_valid` afterwards, all outputs 0. A new operation after reset completes in 4 cycles.
- Saturation (`ADDSUB_SAT_EN`):
  - 0x7FFF + 0x0001 with `sat=1` → res 0x7FFF, ovf=1.
  - 0x8000 − 0x0001 with `sat=1` → res 0x8000, ovf=1.
  - The same operations with `sat=0` → wrapped results.
